// File: rtl/pci_bus_arbiter.sv
// Central PCI bus arbiter: round-robin REQ_/GNT_ arbitration with bus-ownership tracking,
// idle-grant timeout and preemption of a busy owner when another master requests.
module pci_bus_arbiter #(
    parameter int unsigned NUM_MASTERS = 4,
    parameter int unsigned TIMEOUT     = 16
) (
    input  logic                           clk,
    input  logic                           reset_,
    input  logic [NUM_MASTERS-1:0]         REQ_,
    input  logic                           FRAME_,
    input  logic                           IRDY_,
    output logic [NUM_MASTERS-1:0]         GNT_,
    output logic [$clog2(NUM_MASTERS)-1:0] owner_id,
    output logic                           owner_valid,
    output logic                           timeout_evt
);

    localparam int unsigned IdW  = $clog2(NUM_MASTERS);
    localparam int unsigned CntW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {StIdle, StGnt, StBusy, StTurn} state_e;

    state_e                 state_q, state_d;
    logic [NUM_MASTERS-1:0] gnt_q, gnt_d;
    logic [IdW-1:0]         owner_q, owner_d;
    logic [IdW-1:0]         rr_q, rr_d;
    logic                   valid_q, valid_d;
    logic                   tevt_q, tevt_d;
    logic [CntW-1:0]        cnt_q, cnt_d;

    logic                   win_found;
    logic [IdW-1:0]         win_idx;
    logic [IdW-1:0]         cand;
    logic [NUM_MASTERS-1:0] one_hot_owner;
    logic [NUM_MASTERS-1:0] one_hot_win;
    logic                   others_req;
    logic                   go_turn;

    // Search upward from rr_q, wrapping, for the first active-low request.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
            cand = IdW'((32'(rr_q) + i) % NUM_MASTERS);
            if (!win_found && !REQ_[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        one_hot_owner = NUM_MASTERS'(1) << owner_q;
        one_hot_win   = NUM_MASTERS'(1) << win_idx;
        others_req    = |(~REQ_ & ~one_hot_owner);
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        owner_d = owner_q;
        rr_d    = rr_q;
        valid_d = valid_q;
        tevt_d  = 1'b0;
        cnt_d   = cnt_q;
        go_turn = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (win_found) begin
                    state_d = StGnt;
                    gnt_d   = ~one_hot_win;
                    owner_d = win_idx;
                    valid_d = 1'b1;
                    cnt_d   = '0;
                end
            end
            StGnt: begin
                // FRAME_ takes precedence over withdrawal and timeout in the same cycle.
                if (!FRAME_) begin
                    state_d = StBusy;
                end else if (REQ_[owner_q]) begin
                    go_turn = 1'b1;
                end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
                    go_turn = 1'b1;
                    tevt_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StBusy: begin
                // Preemption is sticky: once released, the grant is never re-asserted here.
                if (others_req) begin
                    gnt_d = '1;
                end
                if (FRAME_ && IRDY_) begin
                    go_turn = 1'b1;
                end
            end
            StTurn: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        if (go_turn) begin
            state_d = StTurn;
            gnt_d   = '1;
            valid_d = 1'b0;
            rr_d    = IdW'((32'(owner_q) + 1) % NUM_MASTERS);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_) begin
            state_q <= StIdle;
            gnt_q   <= '1;
            owner_q <= '0;
            rr_q    <= '0;
            valid_q <= 1'b0;
            tevt_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
            valid_q <= valid_d;
            tevt_q  <= tevt_d;
            cnt_q   <= cnt_d;
        end
    end

    assign GNT_        = gnt_q;
    assign owner_id    = owner_q;
    assign owner_valid = valid_q;
    assign timeout_evt = tevt_q;

endmodule

// File: tb/tb_pci_bus_arbiter.sv
// Self-checking bench for pci_bus_arbiter: a per-cycle reference model feeds a scoreboard
// queue, plus directed constant checks at the interesting points of each scenario.
module tb_pci_bus_arbiter;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       reset_;
    logic [3:0] REQ_;
    logic       FRAME_;
    logic       IRDY_;
    logic [3:0] GNT_;
    logic [1:0] owner_id;
    logic       owner_valid;
    logic       timeout_evt;

    always #5 clk = ~clk;

    pci_bus_arbiter #(
        .NUM_MASTERS(4),
        .TIMEOUT    (16)
    ) dut (
        .clk        (clk),
        .reset_     (reset_),
        .REQ_       (REQ_),
        .FRAME_     (FRAME_),
        .IRDY_      (IRDY_),
        .GNT_       (GNT_),
        .owner_id   (owner_id),
        .owner_valid(owner_valid),
        .timeout_evt(timeout_evt)
    );

    typedef struct packed {
        logic [3:0] gnt;
        logic       ov;
        logic [1:0] oid;
        logic       tev;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model state: 0 idle, 1 granted, 2 busy, 3 turnaround.
    int         m_state = 0;
    int         m_ptr   = 0;
    int         m_owner = 0;
    int         m_cnt   = 0;
    logic [3:0] m_gnt   = 4'hF;
    logic       m_ov    = 1'b0;
    logic       m_tev   = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_step(input logic rstn, input logic [3:0] req, input logic frame,
                              input logic irdy);
        bit leave;
        leave = 1'b0;
        m_tev = 1'b0;
        if (!rstn) begin
            m_state = 0;
            m_ptr   = 0;
            m_owner = 0;
            m_cnt   = 0;
            m_gnt   = 4'hF;
            m_ov    = 1'b0;
            return;
        end
        case (m_state)
            0: begin
                for (int k = 0; k < N; k++) begin
                    int w;
                    w = (m_ptr + k) % N;
                    if (req[w] == 1'b0) begin
                        m_gnt    = 4'hF;
                        m_gnt[w] = 1'b0;
                        m_owner  = w;
                        m_cnt    = 0;
                        m_ov     = 1'b1;
                        m_state  = 1;
                        break;
                    end
                end
            end
            1: begin
                if (!frame) m_state = 2;
                else if (req[m_owner]) leave = 1'b1;
                else if (m_cnt == 15) begin
                    leave = 1'b1;
                    m_tev = 1'b1;
                end else m_cnt++;
            end
            2: begin
                for (int k = 0; k < N; k++)
                    if (k != m_owner && !req[k]) m_gnt = 4'hF;
                if (frame && irdy) leave = 1'b1;
            end
            default: m_state = 0;
        endcase
        if (leave) begin
            m_state = 3;
            m_gnt   = 4'hF;
            m_ov    = 1'b0;
            m_ptr   = (m_owner + 1) % N;
        end
    endtask

    task automatic cycle(input logic rstn, input logic [3:0] req, input logic frame,
                         input logic irdy);
        exp_t e;
        reset_ = rstn;
        REQ_   = req;
        FRAME_ = frame;
        IRDY_  = irdy;
        model_step(rstn, req, frame, irdy);
        e.gnt = m_gnt;
        e.ov  = m_ov;
        e.oid = 2'(m_owner);
        e.tev = m_tev;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check("gnt", 32'(GNT_), 32'(e.gnt));
        check("owner_valid", 32'(owner_valid), 32'(e.ov));
        check("owner_id", 32'(owner_id), 32'(e.oid));
        check("timeout_evt", 32'(timeout_evt), 32'(e.tev));
        check("gnt_onehot", 32'($countones(~GNT_) <= 1), 32'd1);
    endtask

    initial begin
        logic [3:0] g;
        reset_ = 1'b0;
        REQ_   = 4'hF;
        FRAME_ = 1'b1;
        IRDY_  = 1'b1;

        // Basic grant, transaction, turnaround.
        cycle(1'b0, 4'b1111, 1'b1, 1'b1);
        check("rst_gnt", 32'(GNT_), 32'hF);
        check("rst_valid", 32'(owner_valid), 32'd0);
        cycle(1'b1, 4'b1110, 1'b1, 1'b1);
        check("t1_gnt", 32'(GNT_), 32'b1110);
        cycle(1'b1, 4'b1110, 1'b0, 1'b1);
        cycle(1'b1, 4'b1110, 1'b0, 1'b0);
        cycle(1'b1, 4'b1111, 1'b1, 1'b1);
        check("t1_turn_gnt", 32'(GNT_), 32'hF);
        check("t1_turn_valid", 32'(owner_valid), 32'd0);
        cycle(1'b1, 4'b1111, 1'b1, 1'b1);

        // Round robin with all masters requesting.
        cycle(1'b0, 4'b1111, 1'b1, 1'b1);
        for (int t = 0; t < 5; t++) begin
            cycle(1'b1, 4'b0000, 1'b1, 1'b1);
            g = 4'hF;
            g[t % 4] = 1'b0;
            check("rr_owner", 32'(owner_id), 32'(t % 4));
            check("rr_gnt", 32'(GNT_), 32'(g));
            cycle(1'b1, 4'b0000, 1'b0, 1'b1);
            cycle(1'b1, 4'b0000, 1'b1, 1'b1);
            cycle(1'b1, 4'b0000, 1'b1, 1'b1);
        end

        // Idle-grant timeout.
        cycle(1'b0, 4'b1111, 1'b1, 1'b1);
        cycle(1'b1, 4'b1011, 1'b1, 1'b1);
        for (int t = 0; t < 15; t++) cycle(1'b1, 4'b1011, 1'b1, 1'b1);
        check("to_hold_gnt", 32'(GNT_), 32'b1011);
        check("to_hold_evt", 32'(timeout_evt), 32'd0);
        cycle(1'b1, 4'b1011, 1'b1, 1'b1);
        check("to_evt", 32'(timeout_evt), 32'd1);
        check("to_gnt", 32'(GNT_), 32'hF);
        cycle(1'b1, 4'b0110, 1'b1, 1'b1);
        check("to_evt_once", 32'(timeout_evt), 32'd0);
        cycle(1'b1, 4'b0110, 1'b1, 1'b1);
        check("to_next_owner", 32'(owner_id), 32'd3);
        cycle(1'b1, 4'b1111, 1'b1, 1'b1);
        cycle(1'b1, 4'b1111, 1'b1, 1'b1);

        // Preemption of a busy owner.
        cycle(1'b0, 4'b1111, 1'b1, 1'b1);
        cycle(1'b1, 4'b1101, 1'b1, 1'b1);
        cycle(1'b1, 4'b1101, 1'b0, 1'b1);
        check("pre_busy_gnt", 32'(GNT_), 32'b1101);
        cycle(1'b1, 4'b0101, 1'b0, 1'b0);
        check("pre_gnt", 32'(GNT_), 32'hF);
        check("pre_valid", 32'(owner_valid), 32'd1);
        cycle(1'b1, 4'b0111, 1'b0, 1'b0);
        cycle(1'b1, 4'b0111, 1'b1, 1'b1);
        cycle(1'b1, 4'b0111, 1'b1, 1'b1);
        check("pre_wait_gnt", 32'(GNT_), 32'hF);
        cycle(1'b1, 4'b0111, 1'b1, 1'b1);
        check("pre_new_gnt", 32'(GNT_), 32'b0111);
        cycle(1'b1, 4'b1111, 1'b1, 1'b1);
        cycle(1'b1, 4'b1111, 1'b1, 1'b1);

        // FRAME_ beats withdrawal, and beats timeout.
        cycle(1'b0, 4'b1111, 1'b1, 1'b1);
        cycle(1'b1, 4'b1110, 1'b1, 1'b1);
        cycle(1'b1, 4'b1111, 1'b0, 1'b1);
        check("fw_valid", 32'(owner_valid), 32'd1);
        check("fw_gnt", 32'(GNT_), 32'b1110);
        cycle(1'b1, 4'b1111, 1'b1, 1'b1);
        cycle(1'b1, 4'b1111, 1'b1, 1'b1);
        cycle(1'b1, 4'b1110, 1'b1, 1'b1);
        for (int t = 0; t < 15; t++) cycle(1'b1, 4'b1110, 1'b1, 1'b1);
        cycle(1'b1, 4'b1110, 1'b0, 1'b1);
        check("ft_evt", 32'(timeout_evt), 32'd0);
        check("ft_valid", 32'(owner_valid), 32'd1);
        check("ft_gnt", 32'(GNT_), 32'b1110);
        cycle(1'b1, 4'b1111, 1'b1, 1'b1);
        cycle(1'b1, 4'b1111, 1'b1, 1'b1);

        // Reset in the middle of a busy transaction.
        cycle(1'b0, 4'b1111, 1'b1, 1'b1);
        cycle(1'b1, 4'b1110, 1'b1, 1'b1);
        cycle(1'b1, 4'b1110, 1'b0, 1'b1);
        cycle(1'b1, 4'b1111, 1'b1, 1'b1);
        cycle(1'b1, 4'b1111, 1'b1, 1'b1);
        cycle(1'b1, 4'b1101, 1'b1, 1'b1);
        cycle(1'b1, 4'b1101, 1'b0, 1'b0);
        check("mr_busy_gnt", 32'(GNT_), 32'b1101);
        cycle(1'b0, 4'b0000, 1'b0, 1'b0);
        check("mr_gnt", 32'(GNT_), 32'hF);
        check("mr_valid", 32'(owner_valid), 32'd0);
        cycle(1'b1, 4'b0000, 1'b1, 1'b1);
        check("mr_restart_owner", 32'(owner_id), 32'd0);
        check("mr_restart_gnt", 32'(GNT_), 32'b1110);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
